// File: rtl/kisc_bus_pkg.sv
// rtl/kisc_bus_pkg.sv - shared LSU state, cause and size encodings
package kisc_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } lsu_state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_BUS     = 2'd1,
      CAUSE_ALIGN   = 2'd2,
      CAUSE_TIMEOUT = 2'd3
   } lsu_cause_e;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - byte-lane write steering, strobes and load extract/extend
module lsu_lane import kisc_bus_pkg::*; #(
   parameter  int DATA_WIDTH = 32,
   localparam int NB         = DATA_WIDTH / 8,
   localparam int OW         = $clog2(NB)
) (
   input  logic [OW-1:0]         off,
   input  logic [1:0]            size,
   input  logic                  zext,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] prdata,
   output logic [DATA_WIDTH-1:0] pdata,
   output logic [NB-1:0]         pstb,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] keep;
   logic [7:0]            lane_mask;
   logic                  sign;

   always_comb begin
      pdata     = wdata << {off, 3'b000};
      shifted   = prdata >> {off, 3'b000};
      keep      = '1;
      lane_mask = 8'hFF;
      sign      = 1'b0;
      // dword loads keep sign = 0: they already fill the whole bus
      case (size)
         SZ_B: begin
            keep      = DATA_WIDTH'(8'hFF);
            lane_mask = 8'h01;
            sign      = shifted[7];
         end
         SZ_H: begin
            keep      = DATA_WIDTH'(16'hFFFF);
            lane_mask = 8'h03;
            sign      = shifted[15];
         end
         SZ_W: begin
            keep      = DATA_WIDTH'(32'hFFFF_FFFF);
            lane_mask = 8'h0F;
            sign      = shifted[31];
         end
         default: ;
      endcase
      pstb  = NB'(lane_mask) << off;
      rdata = (shifted & keep) | ((sign && !zext) ? ~keep : '0);
   end

endmodule

// File: rtl/apb_lsu.sv
// rtl/apb_lsu.sv - APB load/store unit top; LSU_TIMEOUT_EN enables the ACCESS-phase timeout
module apb_lsu import kisc_bus_pkg::*; #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rts_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [1:0]              req_size,
   input  logic                    req_unsigned,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic [1:0]              rsp_cause,
   output logic [ADDR_WIDTH-1:0]   APB_paddr,
   output logic [DATA_WIDTH-1:0]   APB_pdata,
   input  logic [DATA_WIDTH-1:0]   APB_prdata,
   output logic                    APB_psel,
   output logic                    APB_penable,
   output logic                    APB_pwrite,
   output logic [DATA_WIDTH/8-1:0] APB_pstb,
   input  logic                    APB_pready,
   input  logic                    APB_perr
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int OW = $clog2(NB);

   if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
   begin : g_param_check
      $error("apb_lsu: illegal DATA_WIDTH or TIMEOUT_CYCLES");
   end

   lsu_state_e            state, state_nxt;
   lsu_cause_e            cause_q;
   logic                  ready_q;
   logic                  accept;
   logic                  bad_req;
   logic                  timed_out;
   logic                  finish;
   logic [OW-1:0]         off_q, lane_off;
   logic [1:0]            size_q, lane_size;
   logic                  zext_q;
   logic [DATA_WIDTH-1:0] lane_pdata, lane_rdata, rdata_q;
   logic [NB-1:0]         lane_pstb;

   assign accept  = req_valid && ready_q;
   assign bad_req = ((req_size == SZ_D) && (DATA_WIDTH == 32)) ||
                    ((req_addr[2:0] & 3'(size_bytes(req_size) - 4'd1)) != 3'd0);
   assign finish  = (state == ACCESS) && (APB_pready || timed_out);

`ifdef LSU_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] to_cnt;

   always_ff @(posedge clk or negedge rts_n) begin
      if (!rts_n)
         to_cnt <= '0;
      else if (state_nxt == SETUP)
         to_cnt <= '0;
      else if (state == ACCESS)
         to_cnt <= to_cnt + CW'(1);
   end

   // a pready in the limit cycle still completes the transfer normally
   assign timed_out = (state == ACCESS) && !APB_pready && (to_cnt == CW'(TIMEOUT_CYCLES));
`else
   assign timed_out = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = bad_req ? RESP : SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (APB_pready || timed_out) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rts_n) begin
      if (!rts_n) begin
         state   <= IDLE;
         ready_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         ready_q <= (state_nxt == IDLE);
      end
   end

   // request steering uses the live request in IDLE, the latched one afterwards
   assign lane_off  = (state == IDLE) ? req_addr[OW-1:0] : off_q;
   assign lane_size = (state == IDLE) ? req_size : size_q;

   lsu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .off    (lane_off),
      .size   (lane_size),
      .zext   (zext_q),
      .wdata  (req_wdata),
      .prdata (APB_prdata),
      .pdata  (lane_pdata),
      .pstb   (lane_pstb),
      .rdata  (lane_rdata)
   );

   always_ff @(posedge clk or negedge rts_n) begin
      if (!rts_n) begin
         off_q      <= '0;
         size_q     <= SZ_B;
         zext_q     <= 1'b0;
         APB_paddr  <= '0;
         APB_pdata  <= '0;
         APB_pwrite <= 1'b0;
         APB_pstb   <= '0;
      end else if ((state == IDLE) && accept) begin
         off_q  <= req_addr[OW-1:0];
         size_q <= req_size;
         zext_q <= req_unsigned;
         if (!bad_req) begin
            APB_paddr  <= {req_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
            APB_pwrite <= req_write;
            APB_pdata  <= req_write ? lane_pdata : '0;
            APB_pstb   <= req_write ? lane_pstb : '0;
         end
      end else if (finish) begin
         APB_paddr  <= '0;
         APB_pdata  <= '0;
         APB_pwrite <= 1'b0;
         APB_pstb   <= '0;
      end
   end

   always_ff @(posedge clk or negedge rts_n) begin
      if (!rts_n) begin
         rdata_q <= '0;
         cause_q <= CAUSE_NONE;
      end else if ((state == IDLE) && accept && bad_req) begin
         rdata_q <= '0;
         cause_q <= CAUSE_ALIGN;
      end else if (finish) begin
         if (!APB_pready) begin
            rdata_q <= '0;
            cause_q <= CAUSE_TIMEOUT;
         end else if (APB_perr) begin
            rdata_q <= '0;
            cause_q <= CAUSE_BUS;
         end else begin
            rdata_q <= APB_pwrite ? '0 : lane_rdata;
            cause_q <= CAUSE_NONE;
         end
      end
   end

   assign req_ready   = ready_q;
   assign APB_psel    = (state == SETUP) || (state == ACCESS);
   assign APB_penable = (state == ACCESS);
   assign rsp_valid   = (state == RESP);
   assign rsp_rdata   = rsp_valid ? rdata_q : '0;
   assign rsp_err     = rsp_valid && (cause_q != CAUSE_NONE);
   assign rsp_cause   = rsp_valid ? cause_q : CAUSE_NONE;

endmodule

// File: tb/tb_apb_lsu.sv
// tb/tb_apb_lsu.sv - scoreboard bench for apb_lsu with APB slave model
module tb_apb_lsu;

   localparam int TO = 255;
`ifdef LSU_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rts_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [1:0]  req_size = '0;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [1:0]  rsp_cause;
   logic [31:0] APB_paddr;
   logic [31:0] APB_pdata;
   logic [31:0] APB_prdata = '0;
   logic        APB_psel, APB_penable, APB_pwrite;
   logic [3:0]  APB_pstb;
   logic        APB_pready = 1'b0;
   logic        APB_perr = 1'b0;

   apb_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rts_n(rts_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_cause(rsp_cause),
      .APB_paddr(APB_paddr), .APB_pdata(APB_pdata), .APB_prdata(APB_prdata),
      .APB_psel(APB_psel), .APB_penable(APB_penable), .APB_pwrite(APB_pwrite),
      .APB_pstb(APB_pstb), .APB_pready(APB_pready), .APB_perr(APB_perr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic [1:0]  cause;
      int          at;
   } rsp_t;

   typedef struct {
      logic [31:0] paddr;
      logic        wr;
      logic [3:0]  stb;
      logic [31:0] pdata;
      int          waits;
      logic        perr;
      logic [31:0] prdata;
   } bus_t;

   rsp_t exp_q[$];
   bus_t bus_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] model_load(logic [31:0] addr, int size, bit uns, logic [31:0] prdata);
      longint unsigned nb   = 64'd1 << size;
      longint unsigned off  = addr % 4;
      longint unsigned span = 64'd1 << (8 * nb);
      longint unsigned p    = prdata;
      longint unsigned v;
      v = (p >> (8 * off)) % span;
      if (!uns && nb < 4 && v >= span / 2)
         v = v + (64'h1_0000_0000 - span);
      return v[31:0];
   endfunction

   task automatic do_req(bit wr, logic [31:0] addr, int size, bit uns, logic [31:0] wdata,
                         int waits, bit perr, logic [31:0] prdata, bit expect_rsp);
      int   n = 0;
      int   nb = 1 << size;
      bit   ok;
      bit   tmo;
      rsp_t r;
      bus_t b;
      ok  = (size != 3) && (addr % nb == 0);
      tmo = ok && TO_EN && (waits > TO);
      req_valid    = 1'b1;
      req_write    = wr;
      req_addr     = addr;
      req_size     = 2'(size);
      req_unsigned = uns;
      req_wdata    = wdata;
      while (!req_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL req_ready_wait actual=0 required=1 (cycle %0d)", cyc);
         req_valid = 1'b0;
         return;
      end
      if (ok) begin
         b.paddr  = addr & 32'hFFFF_FFFC;
         b.wr     = wr;
         b.stb    = wr ? 4'(((1 << nb) - 1) << (addr % 4)) : 4'h0;
         b.pdata  = wr ? 32'(64'(wdata) << (8 * (addr % 4))) : 32'h0;
         b.waits  = waits;
         b.perr   = perr;
         b.prdata = prdata;
         bus_q.push_back(b);
      end
      r.at    = cyc + (!ok ? 1 : tmo ? 3 + TO : 3 + waits);
      r.cause = !ok ? 2'd2 : tmo ? 2'd3 : perr ? 2'd1 : 2'd0;
      r.err   = (r.cause != 2'd0);
      r.rdata = (r.err || wr) ? 32'h0 : model_load(addr, size, uns, prdata);
      if (expect_rsp) exp_q.push_back(r);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // APB slave: plays back the planned wait states and checks each SETUP phase
   initial begin
      int   wl;
      bus_t cur;
      wl = 0;
      cur.perr = 1'b0;
      cur.prdata = '0;
      forever begin
         @(negedge clk);
         if (APB_psel && !APB_penable) begin
            if (bus_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_bus_cycle psel=1 required=0 (cycle %0d)", cyc);
               wl = 0;
            end else begin
               cur = bus_q.pop_front();
               chk("paddr", APB_paddr, cur.paddr);
               chk("pwrite", APB_pwrite, cur.wr);
               chk("pstb", APB_pstb, cur.stb);
               if (cur.wr) chk("pdata", APB_pdata, cur.pdata);
               wl = cur.waits;
            end
            APB_pready = 1'b0;
            APB_perr   = 1'b0;
         end else if (APB_psel && APB_penable) begin
            if (wl == 0) begin
               APB_pready = 1'b1;
               APB_perr   = cur.perr;
               APB_prdata = cur.prdata;
            end else begin
               wl--;
               APB_pready = 1'b0;
               APB_perr   = 1'($urandom_range(0, 1));
               APB_prdata = $urandom;
            end
         end else begin
            APB_pready = 1'b0;
            APB_perr   = 1'b0;
            APB_prdata = $urandom;
         end
      end
   end

   // response monitor
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp rsp_valid=1 required=0 (cycle %0d)", cyc);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_cycle", cyc, e.at);
               chk("rsp_rdata", rsp_rdata, e.rdata);
               chk("rsp_err", rsp_err, e.err);
               chk("rsp_cause", rsp_cause, e.cause);
               chk("rsp_apb_idle", {APB_psel, APB_penable}, 2'b00);
            end
         end
      end
   end

   initial begin
      int          n;
      int          sz;
      logic [31:0] a;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_rsp", {rsp_valid, rsp_err, rsp_cause, rsp_rdata}, '0);
      chk("rst_apb_ctl", {APB_psel, APB_penable, APB_pwrite, APB_pstb}, '0);
      chk("rst_apb_data", {APB_paddr, APB_pdata}, '0);
      rts_n = 1'b1;
      @(negedge clk);

      do_req(1'b1, 32'h1003, 0, 1'b0, 32'h0000_00A5, 0, 1'b0, 32'h0, 1'b1);
      do_req(1'b0, 32'h2002, 1, 1'b0, 32'h0, 0, 1'b0, 32'h8001_1234, 1'b1);
      do_req(1'b0, 32'h2002, 1, 1'b1, 32'h0, 0, 1'b0, 32'h8001_1234, 1'b1);
      do_req(1'b0, 32'h3002, 2, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b1);
      do_req(1'b1, 32'h5000, 2, 1'b0, 32'hDEAD_BEEF, 3, 1'b1, 32'h0, 1'b1);
      do_req(1'b0, 32'h6000, 3, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b1);
      do_req(1'b0, 32'h7001, 0, 1'b0, 32'h0, 2, 1'b0, 32'h0000_8000, 1'b1);

      for (int i = 0; i < 150; i++) begin
         sz = $urandom_range(0, 3);
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & ~(32'((1 << sz) - 1));
         do_req(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom,
                $urandom_range(0, 4), ($urandom_range(0, 5) == 0), $urandom, 1'b1);
      end

`ifdef LSU_TIMEOUT_EN
      do_req(1'b0, 32'h8000, 2, 1'b0, 32'h0, TO + 50, 1'b0, 32'h0, 1'b1);
      do_req(1'b0, 32'h8004, 2, 1'b0, 32'h0, TO, 1'b0, 32'h1357_9BDF, 1'b1);
`endif

      // reset during ACCESS: bus drops at once and the request vanishes
      do_req(1'b0, 32'h4000, 2, 1'b0, 32'h0, 40, 1'b0, 32'h1234_5678, 1'b0);
      @(negedge clk);
      chk("pre_rst_access", {APB_psel, APB_penable}, 2'b11);
      @(posedge clk);
      #2 rts_n = 1'b0;
      #1;
      chk("rst_async_apb", {APB_psel, APB_penable}, 2'b00);
      repeat (3) @(negedge clk);
      rts_n = 1'b1;
      do_req(1'b0, 32'h4001, 0, 1'b1, 32'h0, 1, 1'b0, 32'hCAFE_F00D, 1'b1);

      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      chk("rsp_queue_drained", exp_q.size(), 0);
      chk("bus_queue_drained", bus_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_lsu.md
# apb_lsu

Parametrised APB load/store unit, the next-generation memory port for the KISC-V core. It accepts one load or store request at a time from the core's execute stage and runs it as an APB transaction. It handles byte-lane steering and sign/zero extension, checks alignment, honours wait states, and reports bus errors and timeouts back to the core with a cause code. It sits between the microcoded core and the APB interconnect, replacing the inline address/strobe logic in the core.

## Interface
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width; only 32 or 64 are legal. NB = DATA_WIDTH/8 byte lanes.
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase cycles before abort; range 1..65535.
- clk  in  1  clock; everything is rising-edge.
- rts_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DATA_WIDTH is 64).
- req_unsigned  in  1  zero-extend load (LBU/LHU/LWU).
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and on error.
- rsp_err  out  1  response is an error.
- rsp_cause  out  2  0 none, 1 bus error (APB_perr), 2 misaligned/illegal size, 3 timeout.
- APB_paddr  out  ADDR_WIDTH  address aligned down to NB.
- APB_pdata  out  DATA_WIDTH  lane-steered write data.
- APB_prdata  in  DATA_WIDTH  read data.
- APB_psel, APB_penable, APB_pwrite  out  1 each  APB control.
- APB_pstb  out  NB  write strobes; all zero on reads.
- APB_pready, APB_perr  in  1 each  APB completion and error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: on req_valid, latch all req_* fields.
  - Misaligned request (addr mod 2^size ≠ 0) or illegal size goes to RESP with cause 2; no bus cycle is issued.
  - Any other request goes to SETUP.
- SETUP: psel=1, penable=0. Go to ACCESS.
- ACCESS: psel=1, penable=1.
  - pready=1: go to RESP. If perr is also 1, cause 1 and rdata 0.
  - pready=0: stay in ACCESS; timeout counter increments.
- RESP: rsp_valid=1 for one cycle; all APB controls are low. Go to IDLE.
- Lane offset is off = addr mod NB.
  - Write: APB_pdata = wdata << 8·off. APB_pstb = ((1<<2^size)−1) << off.
  - Read: shift APB_prdata right by 8·off, mask to 2^size bytes, then sign-extend unless req_unsigned. A dword read is never extended.
- APB_paddr, APB_pdata, APB_pwrite and APB_pstb are registered on acceptance and held stable through SETUP and ACCESS.

## Timing
- Every output resets to 0. FSM resets to IDLE; timeout counter resets to 0.
- Zero-wait access: request accepted at cycle 0, SETUP at 1, ACCESS at 2 with pready, rsp_valid at 3. Each wait state adds one cycle.
- Misaligned request: accepted at cycle 0, rsp_valid at 1.
- The next request can be accepted the cycle after RESP. Peak throughput is one transfer per 4 cycles.
- perr is sampled only when pready=1 in ACCESS.
- Reset asserted mid-transfer: psel/penable drop asynchronously. No response is issued and the latched request is discarded.
- req_valid outside IDLE is ignored, because req_ready is low.

## Configuration
- LSU_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) runs in ACCESS and clears on entering SETUP.
  - When it reaches TIMEOUT_CYCLES with pready still 0, the FSM goes to RESP with cause 3 and psel/penable drop.
  - A pready arriving in that same cycle wins: the transfer completes normally.
- LSU_TIMEOUT_EN undefined: no counter. ACCESS waits indefinitely and cause 3 is never produced.

## Structure
- Package kisc_bus_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS/RESP);
  - the cause enum (CAUSE_NONE/BUS/ALIGN/TIMEOUT);
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - a function giving the byte count for a size.
- One combinational sub-module, lsu_lane, owns write steering, strobe generation and read extract/extend. It is parametrised on DATA_WIDTH.

## Test plan
- Store byte 0xA5 at 0x1003, DATA_WIDTH=32, zero waits:
  - APB_paddr=0x1000, pstb=4'b1000, pdata=0xA5000000;
  - rsp_valid at cycle 3, cause 0.
- Load half at 0x2002, prdata=0x8001_1234:
  - signed: rsp_rdata=0xFFFF8001;
  - req_unsigned: rsp_rdata=0x00008001.
- Load word at 0x3002 → rsp_valid at cycle 1, cause 2, psel never asserted.
- Store word with 3 wait states, then pready with perr=1 → rsp_valid at cycle 6, cause 1, rsp_rdata=0.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready held 0 → ACCESS lasts 5 cycles, then penable/psel drop and cause 3. Rerun with pready=1 on the final ACCESS cycle → normal completion.
- Assert rts_n low during ACCESS → psel/penable 0 immediately, no rsp_valid. After release, a new load completes normally.
